// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-only data memory.
// Handles sub-word extraction/extension and read-modify-write for sb/sh.
module load_store_unit #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_out
);

  localparam logic [31:0] MemWordsU = 32'(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q, buf_q;
  logic [2:0]  funct3_q;
  logic        store_q, err_q;

  logic        legal, misal, oor, reqErr, accept;
  logic [31:0] merged, loadData;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  assign accept = (state_q == IDLE) && req_valid;

  // Request decode works on the live inputs so the error path skips memory entirely.
  always_comb begin
    legal = 1'b0;
    misal = 1'b0;
    case (req_funct3)
      3'b000: legal = 1'b1;
      3'b001: begin legal = 1'b1; misal = req_addr[0]; end
      3'b010: begin legal = 1'b1; misal = |req_addr[1:0]; end
      3'b100: legal = !req_store;
      3'b101: begin legal = !req_store; misal = req_addr[0]; end
      default: legal = 1'b0;
    endcase
    oor    = {2'b00, req_addr[31:2]} >= MemWordsU;
    reqErr = !legal || misal || oor;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
      err_q    <= 1'b0;
      buf_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        funct3_q <= req_funct3;
        store_q  <= req_store;
        err_q    <= reqErr;
      end
      if (state_q == READ) buf_q <= mem_out;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (reqErr)                               state_d = DONE;
          else if (req_store && req_funct3 == 3'b010) state_d = WRITE;
          else                                      state_d = READ;
        end
      end
      READ:    state_d = store_q ? WRITE : DONE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Little-endian merge of store data into the word captured during READ.
  always_comb begin
    merged = buf_q;
    case (funct3_q[1:0])
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    laneByte = buf_q[{addr_q[1:0], 3'b000} +: 8];
    laneHalf = buf_q[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  loadData = {{24{laneByte[7]}}, laneByte};
      3'b001:  loadData = {{16{laneHalf[15]}}, laneHalf};
      3'b100:  loadData = {24'h0, laneByte};
      3'b101:  loadData = {16'h0, laneHalf};
      default: loadData = buf_q;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_addr   = '0;
    mem_din    = '0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    case (state_q)
      IDLE: req_ready = 1'b1;
      READ: begin
        mem_re   = 1'b1;
        mem_addr = {2'b00, addr_q[31:2]};
      end
      WRITE: begin
        mem_we   = 1'b1;
        mem_addr = {2'b00, addr_q[31:2]};
        mem_din  = merged;
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || store_q) ? 32'h0 : loadData;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a small word memory model.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_out;

  logic [31:0] memModel [0:255];
  int assertCount = 0;
  int failCount   = 0;

  load_store_unit #(.MEM_WORDS(256)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_we(mem_we), .mem_re(mem_re), .mem_out(mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_out = (mem_re && mem_addr < 32'd256) ? memModel[mem_addr[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_we && mem_addr < 32'd256) memModel[mem_addr[7:0]] <= mem_din;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issue one request, follow it to its response and check timing, data and memory traffic.
  task automatic applyStimulus(input string tag, input logic st, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int expLat, input logic [31:0] expRdata,
                               input logic expErr, input logic [31:0] expDin);
    int          lat;
    logic        sawRe, sawWe, both, addrBad;
    logic [31:0] din;
    logic        expRe, expWe;
    expRe = !expErr && !(st && f3 == 3'b010);
    expWe = !expErr && st;
    sawRe = 0; sawWe = 0; both = 0; addrBad = 0; din = '0;
    @(negedge clk);
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
      if (mem_re) begin sawRe = 1; if (mem_addr !== (addr >> 2)) addrBad = 1; end
      if (mem_we) begin sawWe = 1; din = mem_din; if (mem_addr !== (addr >> 2)) addrBad = 1; end
      if (mem_re && mem_we) both = 1;
    end while (!resp_valid && lat < 8);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_rdata"}, resp_rdata, expRdata);
    checkOutput({tag, "_err"}, 32'(resp_err), 32'(expErr));
    checkOutput({tag, "_re_seen"}, 32'(sawRe), 32'(expRe));
    checkOutput({tag, "_we_seen"}, 32'(sawWe), 32'(expWe));
    if (expWe) checkOutput({tag, "_din"}, din, expDin);
    checkOutput({tag, "_mem_addr_bad"}, 32'(addrBad), 32'd0);
    checkOutput({tag, "_re_we_overlap"}, 32'(both), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_pulse_one_cycle"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int  lat;
    logic sawResp;
    for (int i = 0; i < 256; i++) memModel[i] = 32'h0;
    memModel[3]   = 32'd17;
    memModel[255] = 32'h1234_5678;
    rst = 1'b1; req_valid = 0; req_store = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    #12;
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_re", 32'(mem_re), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_din", mem_din, 32'h0);
    @(negedge clk); rst = 1'b0;
    #1 checkOutput("rst_ready_after", 32'(req_ready), 32'd1);

    applyStimulus("lw12",   0, 3'b010, 32'd12, 32'h0,        2, 32'h0000_0011, 0, 32'h0);
    applyStimulus("sb13",   1, 3'b000, 32'd13, 32'h1234_56AB, 3, 32'h0,        0, 32'h0000_AB11);
    applyStimulus("lb13",   0, 3'b000, 32'd13, 32'h0,        2, 32'hFFFF_FFAB, 0, 32'h0);
    applyStimulus("lbu13",  0, 3'b100, 32'd13, 32'h0,        2, 32'h0000_00AB, 0, 32'h0);
    applyStimulus("sh14",   1, 3'b001, 32'd14, 32'hCAFE_8001, 3, 32'h0,        0, 32'h8001_AB11);
    applyStimulus("lh14",   0, 3'b001, 32'd14, 32'h0,        2, 32'hFFFF_8001, 0, 32'h0);
    applyStimulus("lhu14",  0, 3'b101, 32'd14, 32'h0,        2, 32'h0000_8001, 0, 32'h0);
    applyStimulus("lh12",   0, 3'b001, 32'd12, 32'h0,        2, 32'hFFFF_AB11, 0, 32'h0);
    applyStimulus("sw16",   1, 3'b010, 32'd16, 32'hDEAD_BEEF, 2, 32'h0,        0, 32'hDEAD_BEEF);
    applyStimulus("lw16",   0, 3'b010, 32'd16, 32'h0,        2, 32'hDEAD_BEEF, 0, 32'h0);
    applyStimulus("lw1020", 0, 3'b010, 32'd1020, 32'h0,      2, 32'h1234_5678, 0, 32'h0);
    applyStimulus("lw14_mis",   0, 3'b010, 32'd14,   32'h0,  1, 32'h0, 1, 32'h0);
    applyStimulus("lw1024_oor", 0, 3'b010, 32'd1024, 32'h0,  1, 32'h0, 1, 32'h0);
    applyStimulus("f3_011_ill", 0, 3'b011, 32'd12,   32'h0,  1, 32'h0, 1, 32'h0);
    applyStimulus("lh13_mis",   0, 3'b001, 32'd13,   32'h0,  1, 32'h0, 1, 32'h0);
    applyStimulus("st_f3_100",  1, 3'b100, 32'd12,   32'h55, 1, 32'h0, 1, 32'h0);
    applyStimulus("sw13_mis",   1, 3'b010, 32'd13,   32'h55, 1, 32'h0, 1, 32'h0);
    checkOutput("mem3_after_errors", memModel[3], 32'h8001_AB11);

    // Abort an sb in WRITE: the store must not land and no response may follow.
    @(negedge clk);
    req_valid = 1; req_store = 1; req_funct3 = 3'b000; req_addr = 32'd12; req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk); req_valid = 0;
    @(negedge clk);
    checkOutput("abort_in_write_we", 32'(mem_we), 32'd1);
    checkOutput("abort_in_write_din", mem_din, 32'h8001_AB55);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_we_dropped", 32'(mem_we), 32'd0);
    checkOutput("abort_din_cleared", mem_din, 32'h0);
    checkOutput("abort_addr_cleared", mem_addr, 32'h0);
    @(negedge clk); rst = 1'b0;
    sawResp = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid) sawResp = 1;
    end
    checkOutput("abort_no_resp", 32'(sawResp), 32'd0);
    checkOutput("abort_ready", 32'(req_ready), 32'd1);
    checkOutput("abort_mem3_unchanged", memModel[3], 32'h8001_AB11);
    applyStimulus("abort_readback", 0, 3'b010, 32'd12, 32'h0, 2, 32'h8001_AB11, 0, 32'h0);

    // req_valid held across two requests; changing inputs while busy must not disturb the first.
    @(negedge clk);
    req_valid = 1; req_store = 0; req_funct3 = 3'b010; req_addr = 32'd16; req_wdata = 0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("b2b_busy_ready", 32'(req_ready), 32'd0);
    checkOutput("b2b_first_addr", mem_addr, 32'd4);
    req_addr = 32'd12;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("b2b_first_latency", 32'(lat), 32'd2);
    checkOutput("b2b_first_rdata", resp_rdata, 32'hDEAD_BEEF);
    checkOutput("b2b_done_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    checkOutput("b2b_idle_ready", 32'(req_ready), 32'd1);
    checkOutput("b2b_idle_resp", 32'(resp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    checkOutput("b2b_second_re", 32'(mem_re), 32'd1);
    checkOutput("b2b_second_addr", mem_addr, 32'd3);
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("b2b_second_latency", 32'(lat), 32'd2);
    checkOutput("b2b_second_rdata", resp_rdata, 32'h8001_AB11);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
